// File: rtl/pingpong_operand_queue_if.sv
// Host write stream, control and per-channel operand outputs of the ping-pong operand queue.
interface pingpong_operand_queue_if #(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    wr_valid_i;
    logic                    wr_ready_o;
    logic [DATA_WIDTH-1:0]   wr_data_i;
    logic                    start_i;
    logic                    abort_i;
    logic [N-1:0]            advance_i;
    logic [N*DATA_WIDTH-1:0] data_o;
    logic [N-1:0]            valid_o;
    logic [N-1:0]            last_o;
    logic                    done_o;
    logic                    busy_o;
    logic [1:0]              bank_full_o;

    modport slave (
        input  wr_valid_i, wr_data_i, start_i, abort_i, advance_i,
        output wr_ready_o, data_o, valid_o, last_o, done_o, busy_o, bank_full_o
    );

    modport master (
        output wr_valid_i, wr_data_i, start_i, abort_i, advance_i,
        input  wr_ready_o, data_o, valid_o, last_o, done_o, busy_o, bank_full_o
    );
endinterface

// File: rtl/pingpong_operand_queue.sv
// Double-buffered operand feeder for one edge of an N-channel systolic array:
// the host fills one bank while the other streams K elements per channel.
module pingpong_operand_queue #(
    parameter int unsigned N          = 8,
    parameter int unsigned K          = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAJOR      = 0,
    parameter int unsigned ADV_DELAY  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    pingpong_operand_queue_if.slave  bus
);
    localparam int unsigned TILE  = N * K;
    localparam int unsigned DEPTH = 2 * TILE;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_e;

    state_e                       state_q, state_d;
    logic [N-1:0][CW-1:0]         cnt_q, cnt_d;
    logic [N-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [N-1:0]                 valid_q, valid_d;
    logic [N-1:0]                 last_q, last_d;
    logic                         done_q, done_d;
    logic                         busy_q, busy_d;
    logic [1:0]                   full_q, full_d;
    logic                         wb_q, wb_d;
    logic                         rb_q, rb_d;
    logic [AW-1:0]                wa_q, wa_d;
    logic [N-1:0]                 adv_eff;
    logic                         wr_ready;
    logic                         all_last;
    logic                         mem_we;
    logic [AW-1:0]                mem_waddr;
    logic [DATA_WIDTH-1:0]        mem_q [DEPTH];

    // Bank-relative element address for the configured layout.
    function automatic logic [AW-1:0] rd_addr(input logic bank, input int unsigned chan,
                                              input int unsigned elem);
        int unsigned a;
        a = (MAJOR != 0) ? (chan * K + elem) : (elem * N + chan);
        if (bank) a = a + TILE;
        return AW'(a);
    endfunction

    // Advance delay line keeps shifting regardless of read state.
    if (ADV_DELAY == 0) begin : g_no_dly
        assign adv_eff = bus.advance_i;
    end else begin : g_dly
        logic [ADV_DELAY-1:0][N-1:0] line_q, line_d;

        always_comb begin
            line_d    = line_q;
            line_d[0] = bus.advance_i;
            for (int unsigned i = 1; i < ADV_DELAY; i++) line_d[i] = line_q[i-1];
            if (bus.abort_i) line_d = '0;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) line_q <= '0;
            else       line_q <= line_d;
        end

        assign adv_eff = line_q[ADV_DELAY-1];
    end

    assign wr_ready = ~full_q[wb_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = '0;
        last_d    = '0;
        full_d    = full_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        wa_d      = wa_q;
        all_last  = 1'b1;
        mem_we    = 1'b0;
        mem_waddr = wa_q + (wb_q ? AW'(TILE) : AW'(0));

        if (bus.wr_valid_i && wr_ready) begin
            mem_we = 1'b1;
            if (wa_q == AW'(TILE - 1)) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
                wa_d         = '0;
            end else begin
                wa_d = wa_q + AW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start_i && full_q[rb_q]) state_d = PRIME;
            end
            PRIME: begin
                for (int unsigned c = 0; c < N; c++) begin
                    cnt_d[c]  = '0;
                    data_d[c] = mem_q[rd_addr(rb_q, c, 0)];
                end
                valid_d = '1;
                if (K == 1) begin
                    last_d  = '1;
                    state_d = DONE;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                for (int unsigned c = 0; c < N; c++) begin
                    if (cnt_q[c] != CW'(K - 1)) all_last = 1'b0;
                    if (adv_eff[c] && (cnt_q[c] < CW'(K - 1))) begin
                        cnt_d[c]   = cnt_q[c] + CW'(1);
                        data_d[c]  = mem_q[rd_addr(rb_q, c, 32'(cnt_q[c]) + 32'd1)];
                        valid_d[c] = 1'b1;
                        last_d[c]  = (cnt_d[c] == CW'(K - 1));
                    end
                end
                // Every channel already showed its last element on an earlier cycle.
                if (all_last) state_d = DONE;
            end
            DONE: begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = '0;
            valid_d = '0;
            last_d  = '0;
            full_d  = '0;
            wb_d    = 1'b0;
            rb_d    = 1'b0;
            wa_d    = '0;
            mem_we  = 1'b0;
        end

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            full_q  <= '0;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            wa_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            full_q  <= full_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            wa_q    <= wa_d;
        end
    end

    // Operand storage carries no reset; full flags gate every read.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[mem_waddr] <= bus.wr_data_i;
    end

    assign bus.wr_ready_o  = wr_ready;
    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.last_o      = last_q;
    assign bus.done_o      = done_q;
    assign bus.busy_o      = busy_q;
    assign bus.bank_full_o = full_q;
endmodule
